// File: rtl/mac_frame_accumulator.sv
// Frame accumulator behind the pipelined multiply-add stage: sums frame_len
// results into one saturating total and hands it off on a valid/ready port.
module mac_frame_accumulator #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 6,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  input  logic [LEN_W-1:0] frame_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [CNT_W-1:0] frames_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [LEN_W:0] LEN_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] LEN_MAX = {1'b1, {LEN_W{1'b0}}};

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic             r_sat, w_sat_nxt;
  logic [LEN_W:0]   r_cnt, w_cnt_nxt;
  logic [LEN_W:0]   r_len, w_len_nxt;
  logic [CNT_W-1:0] r_frames, w_frames_nxt;
  logic             r_out_valid;

  logic             w_accept, w_xfer, w_start;
  logic [LEN_W:0]   w_frame_n, w_cnt_inc;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_sum_clamped;

  assign in_ready = (r_state == S_HOLD) ? out_ready : 1'b1;
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = (r_state == S_HOLD) && out_ready;
  // A sample accepted outside ACCUM always opens a new frame (IDLE, or HOLD
  // while the finished frame is leaving on the same edge).
  assign w_start  = w_accept && (r_state != S_ACCUM);

  assign w_frame_n     = (frame_len == '0) ? LEN_MAX : {1'b0, frame_len};
  assign w_cnt_inc     = r_cnt + LEN_ONE;
  assign w_sum         = (ACC_W+1)'(r_acc) + (ACC_W+1)'(in_data);
  assign w_sum_clamped = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];

  // NOTE: every signal driven here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_sat_nxt    = r_sat;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_frames_nxt = r_frames;

    if (w_xfer) begin
      w_frames_nxt = r_frames + CNT_W'(1);
    end

    if (w_start) begin
      w_acc_nxt   = ACC_W'(in_data);
      w_sat_nxt   = 1'b0;
      w_cnt_nxt   = LEN_ONE;
      w_len_nxt   = w_frame_n;
      w_state_nxt = (w_frame_n == LEN_ONE) ? S_HOLD : S_ACCUM;
    end else if ((r_state == S_ACCUM) && w_accept) begin
      w_acc_nxt = w_sum_clamped;
      w_sat_nxt = r_sat | w_sum[ACC_W];
      w_cnt_nxt = w_cnt_inc;
      if (w_cnt_inc == r_len) begin
        w_state_nxt = S_HOLD;
      end
    end else if (w_xfer) begin
      w_state_nxt = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_frames    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_sat       <= w_sat_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_frames    <= w_frames_nxt;
      r_out_valid <= (w_state_nxt == S_HOLD);
    end
  end

  assign out_valid   = r_out_valid;
  assign out_sum     = r_acc;
  assign out_sat     = r_sat;
  assign frames_done = r_frames;

endmodule
